fp_adder_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor; next generation of the combinational single-precision adder.
- Derives hidden bits internally from the exponent, supports add/sub mode and round-to-nearest-even via guard/round/sticky bits.
- Handles zero, infinity and NaN, and reports exception flags.
- Sits between operand-issue logic and the result writeback, with a valid/ready handshake on both sides.

---
 rtl/fp_adder_pkg.sv | 33 +++
 rtl/fp_align_shifter.sv | 38 +++
 rtl/fp_adder_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp_adder_pkg.sv
// Shared types and helpers for the pipelined floating-point adder:
// special-operand classes, flag bit positions, bias and canonical NaN builders.
package fp_adder_pkg;

  typedef enum logic [1:0] {
    SPEC_NONE = 2'd0,
    SPEC_ZERO = 2'd1,
    SPEC_INF  = 2'd2,
    SPEC_NAN  = 2'd3
  } spec_e;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  // Widest word the helper functions can build; callers slice to their own width.
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right shifter that aligns the smaller significand into {hidden, fraction, G, R, sticky},
// folding every bit shifted past the sticky position into the sticky bit.
module fp_align_shifter #(
  parameter int MAN_W  = 23,
  parameter int DIFF_W = 8
) (
  input  logic [MAN_W:0]    i_man,
  input  logic [DIFF_W-1:0] i_diff,
  output logic [MAN_W+3:0]  o_man
);

  localparam int N = MAN_W + 4;

  logic [N-1:0] w_ext;
  logic [N-1:0] w_shifted;
  logic         w_sticky;

  assign w_ext = {i_man, 3'b000};

  // Shift and collect the bits that fall below the result
  always_comb begin
    w_sticky  = 1'b0;
    w_shifted = w_ext >> i_diff;
    for (int i = 0; i < N; i++) begin
      if (i < int'(i_diff)) begin
        w_sticky = w_sticky | w_ext[i];
      end else begin
        w_sticky = w_sticky;
      end
    end
    if (int'(i_diff) >= MAN_W + 3) begin
      o_man = {{(N-1){1'b0}}, |i_man};
    end else begin
      o_man = {w_shifted[N-1:1], w_shifted[0] | w_sticky};
    end
  end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round/pack) with
// flush-to-zero inputs, round-to-nearest-even, and one stall signal shared by all stages.
module fp_adder_pipe
  import fp_adder_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_flags
);

  localparam int MX   = MAN_W + 4;
  localparam int SW   = MAN_W + 5;
  localparam int LZ_W = $clog2(SW) + 1;
  localparam int XW   = EXP_W + LZ_W + 1;

  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]         NAN_C    = W'(fp_canon_nan(EXP_W, MAN_W));
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] X_ONE    = XW'(1);
  localparam logic [LZ_W-1:0]      LZ_ONE   = LZ_W'(1);

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MX-1:0]    man_l;
    logic [MX-1:0]    man_s;
    logic             eff_sub;
    spec_e            spec;
    logic             spec_sign;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
    spec_e            spec;
    logic             spec_sign;
  } s2_t;

  logic             w_adv;
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb, w_diff;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [MAN_W:0]   w_ma, w_mb, w_m_small;
  logic [MX-1:0]    w_s_aligned;
  logic             w_a_is_l;
  s1_t              w_s1, r_s1;
  s2_t              w_s2, r_s2;

  logic                   r_out_valid;
  logic [W-1:0]           r_out_result;
  logic [2:0]             r_out_flags;

  assign w_adv      = !r_out_valid || out_ready;
  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

  // Stage 1: unpack with denormals flushed, order by magnitude (ties keep A as larger)
  assign w_sa     = in_a[W-1];
  assign w_sb     = in_b[W-1] ^ in_sub;
  assign w_ea     = in_a[W-2:MAN_W];
  assign w_eb     = in_b[W-2:MAN_W];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_ONES) && (in_a[MAN_W-1:0] == '0);
  assign w_b_inf  = (w_eb == EXP_ONES) && (in_b[MAN_W-1:0] == '0);
  assign w_a_nan  = (w_ea == EXP_ONES) && (in_a[MAN_W-1:0] != '0);
  assign w_b_nan  = (w_eb == EXP_ONES) && (in_b[MAN_W-1:0] != '0);
  assign w_ma     = w_a_zero ? '0 : {1'b1, in_a[MAN_W-1:0]};
  assign w_mb     = w_b_zero ? '0 : {1'b1, in_b[MAN_W-1:0]};
  assign w_a_is_l = {w_ea, w_ma[MAN_W-1:0]} >= {w_eb, w_mb[MAN_W-1:0]};
  assign w_diff   = w_a_is_l ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_m_small = w_a_is_l ? w_mb : w_ma;

  fp_align_shifter #(
    .MAN_W  (MAN_W),
    .DIFF_W (EXP_W)
  ) u_align (
    .i_man  (w_m_small),
    .i_diff (w_diff),
    .o_man  (w_s_aligned)
  );

  // Stage 1 record: ordered operands plus special-operand outcome
  always_comb begin
    w_s1           = '0;
    w_s1.valid     = in_valid;
    w_s1.sign      = w_a_is_l ? w_sa : w_sb;
    w_s1.exp       = w_a_is_l ? w_ea : w_eb;
    w_s1.man_l     = {(w_a_is_l ? w_ma : w_mb), 3'b000};
    w_s1.man_s     = w_s_aligned;
    w_s1.eff_sub   = w_sa ^ w_sb;
    w_s1.spec      = SPEC_NONE;
    w_s1.spec_sign = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_s1.spec = SPEC_NAN;
    end else if (w_a_inf && w_b_inf) begin
      if (w_sa != w_sb) begin
        w_s1.spec = SPEC_NAN;
      end else begin
        w_s1.spec      = SPEC_INF;
        w_s1.spec_sign = w_sa;
      end
    end else if (w_a_inf) begin
      w_s1.spec      = SPEC_INF;
      w_s1.spec_sign = w_sa;
    end else if (w_b_inf) begin
      w_s1.spec      = SPEC_INF;
      w_s1.spec_sign = w_sb;
    end else if (w_a_zero && w_b_zero) begin
      w_s1.spec      = SPEC_ZERO;
      w_s1.spec_sign = w_sa & w_sb;
    end else begin
      w_s1.spec = SPEC_NONE;
    end
  end

  // Stage 2: magnitude add or subtract; larger operand first so the result is never negative
  always_comb begin
    w_s2           = '0;
    w_s2.valid     = r_s1.valid;
    w_s2.sign      = r_s1.sign;
    w_s2.exp       = r_s1.exp;
    w_s2.spec      = r_s1.spec;
    w_s2.spec_sign = r_s1.spec_sign;
    if (r_s1.eff_sub) begin
      w_s2.sum = {1'b0, r_s1.man_l} - {1'b0, r_s1.man_s};
    end else begin
      w_s2.sum = {1'b0, r_s1.man_l} + {1'b0, r_s1.man_s};
    end
  end

  logic [LZ_W-1:0]        w_lz;
  logic                   w_found;
  logic [MX-1:0]          w_norm;
  logic signed [XW-1:0]   w_exp_ext, w_lz_ext, w_exp_n, w_exp_r;
  logic                   w_round_up;
  logic [MAN_W+1:0]       w_rounded;
  logic [MAN_W-1:0]       w_frac;
  logic [W-1:0]           w_result;
  logic [2:0]             w_flags;

  assign w_exp_ext = {{(XW-EXP_W){1'b0}}, r_s2.exp};
  assign w_lz_ext  = {{(XW-LZ_W){1'b0}}, w_lz};

  // Leading zeros counted from the hidden-bit position downwards
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = SW - 2; i >= 0; i--) begin
      if (!w_found && !r_s2.sum[i]) begin
        w_lz = w_lz + LZ_ONE;
      end else begin
        w_found = 1'b1;
      end
    end
  end

  // Stage 3: normalise, round to nearest even, then resolve specials and range limits
  always_comb begin
    if (r_s2.sum[SW-1]) begin
      w_norm  = {r_s2.sum[SW-1:2], r_s2.sum[1] | r_s2.sum[0]};
      w_exp_n = w_exp_ext + X_ONE;
    end else begin
      w_norm  = r_s2.sum[SW-2:0] << w_lz;
      w_exp_n = w_exp_ext - w_lz_ext;
    end
    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rounded  = {1'b0, w_norm[MX-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
    if (w_rounded[MAN_W+1]) begin
      w_frac  = w_rounded[MAN_W:1];
      w_exp_r = w_exp_n + X_ONE;
    end else begin
      w_frac  = w_rounded[MAN_W-1:0];
      w_exp_r = w_exp_n;
    end
    w_result = '0;
    w_flags  = 3'b000;
    case (r_s2.spec)
      SPEC_NAN: begin
        w_result               = NAN_C;
        w_flags[FLAG_INVALID]  = 1'b1;
      end
      SPEC_INF:  w_result = {r_s2.spec_sign, EXP_ONES, {MAN_W{1'b0}}};
      SPEC_ZERO: w_result = {r_s2.spec_sign, {(W-1){1'b0}}};
      default: begin
        if (r_s2.sum == '0) begin
          w_result = '0;
        end else if (w_exp_r >= EXP_TOP) begin
          w_result               = {r_s2.sign, EXP_ONES, {MAN_W{1'b0}}};
          w_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (w_exp_r <= EXP_ZERO) begin
          w_result                = {r_s2.sign, {(W-1){1'b0}}};
          w_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
          w_result = {r_s2.sign, w_exp_r[EXP_W-1:0], w_frac};
        end
      end
    endcase
  end

  // Pipeline registers: the whole pipe advances or holds as one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1.valid   <= 1'b0;
      r_s2.valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= 3'b000;
    end else if (w_adv) begin
      r_s1         <= w_s1;
      r_s2         <= w_s2;
      r_out_valid  <= r_s2.valid;
      r_out_result <= w_result;
      r_out_flags  <= w_flags;
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe: single- and half-precision instances covering
// latency, rounding, specials, range exceptions, backpressure and reset while stalled.
module tb_fp_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_result;
  logic [2:0]  h_out_flags;

  fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  fp_adder_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_result(h_out_result), .out_flags(h_out_flags)
  );

  int checks   = 0;
  int failures = 0;
  int sent;
  int stale;
  logic [31:0] got_q [$];

  logic [31:0] bp_a [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
  logic [31:0] bp_b [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000};
  logic        bp_s [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] bp_r [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'hC0000000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] exp_r, input logic [2:0] exp_f,
                       input string tag);
    int          lat;
    logic        got_v;
    logic [31:0] res;
    logic [2:0]  flg;
    @(negedge clk);
    if (half) begin
      h_in_valid = 1'b1; h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_sub = sub;
    end else begin
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    end
    #1 check({tag, ".rdy"}, 32'(half ? h_in_ready : in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    lat   = 0;
    got_v = 1'b0;
    while (!got_v && lat < 10) begin
      @(negedge clk);
      lat++;
      got_v = half ? h_out_valid : out_valid;
    end
    res = half ? {16'h0000, h_out_result} : out_result;
    flg = half ? h_out_flags : out_flags;
    check({tag, ".lat"}, 32'(lat), 32'd3);
    check({tag, ".res"}, res, exp_r);
    check({tag, ".flg"}, 32'(flg), 32'(exp_f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = 16'd0; h_in_b = 16'd0; h_in_sub = 1'b0; h_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.ov",  32'(out_valid), 32'd0);
    check("rst.res", out_result, 32'd0);
    check("rst.flg", 32'(out_flags), 32'd0);
    check("rst.rdy", 32'(in_ready), 32'd1);

    do_op(1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, "one_plus_one");
    do_op(1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "one_minus_one");
    do_op(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "three_minus_one");
    do_op(1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, "tie_even");
    do_op(1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, "tie_up");
    do_op(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, "overflow");
    do_op(1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, "inf_minus_inf");
    do_op(1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "nan_operand");
    do_op(1'b0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, "inf_plus_one");
    do_op(1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, "neg_zero");
    do_op(1'b0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, "underflow");
    do_op(1'b1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 3'b000, "h_one_plus_one");
    do_op(1'b1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 3'b010, "h_overflow");

    // Streamed operations with the consumer stalled for four cycles mid-stream
    sent = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 40 && got_q.size() < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 5);
      if (sent < 5) begin
        in_a = bp_a[sent]; in_b = bp_b[sent]; in_sub = bp_s[sent];
      end
      #1;
      if (out_valid && !out_ready && got_q.size() < 5) begin
        check("bp.hold", out_result, bp_r[got_q.size()]);
        check("bp.rdy_low", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) got_q.push_back(out_result);
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.res%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, bp_r[i]);
    end
    @(negedge clk);
    #1 check("bp.drain", 32'(out_valid), 32'd0);

    // Fill the pipe against a stalled consumer, then reset while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = bp_a[i]; in_b = bp_b[i]; in_sub = bp_s[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rs.stalled_ov",  32'(out_valid), 32'd1);
    check("rs.stalled_res", out_result, bp_r[0]);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check("rs.ov",  32'(out_valid), 32'd0);
    check("rs.rdy", 32'(in_ready), 32'd1);
    check("rs.res", out_result, 32'd0);
    check("rs.flg", 32'(out_flags), 32'd0);
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("rs.stale", 32'(stale), 32'd0);

    do_op(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
